// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite physics controller:
// vertical state encoding, colour palette and default VGA visible-area limits.
package sprite_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        JUMP   = 2'd1,
        FALL   = 2'd2
    } state_t;

    localparam int VGA_H_MIN = 144;
    localparam int VGA_H_MAX = 783;
    localparam int VGA_V_MIN = 35;
    localparam int VGA_V_MAX = 514;

    localparam logic [11:0] BLACK      = 12'h000;
    localparam logic [11:0] RED        = 12'hF00;
    localparam logic [11:0] SAND       = 12'hFF0;
    localparam logic [11:0] BG_DEFAULT = 12'h0FF;
    localparam logic [11:0] BG_R       = 12'h00F;
    localparam logic [11:0] BG_L       = 12'h0F0;
    localparam logic [11:0] BG_D       = 12'hF0F;
    localparam logic [11:0] BG_U       = 12'h888;

endpackage

// File: rtl/sprite_physics_controller_if.sv
// Bundle of button/strobe/pixel inputs and sprite/colour outputs between the
// input conditioning, the physics controller and the display controller.
interface sprite_physics_controller_if;
    logic        move_tick;
    logic        up;
    logic        down;
    logic        left;
    logic        right;
    logic        bright;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic [11:0] rgb;
    logic [11:0] background;
    logic [9:0]  xpos;
    logic [9:0]  ypos;
    logic        airborne;

    modport master (
        output move_tick, up, down, left, right, bright, hCount, vCount,
        input  rgb, background, xpos, ypos, airborne
    );

    modport slave (
        input  move_tick, up, down, left, right, bright, hCount, vCount,
        output rgb, background, xpos, ypos, airborne
    );
endinterface

// File: rtl/sprite_pixel_mux.sv
// Registered pixel painter: sprite box, sand strip and background, blanked
// outside the display area. One clock of latency from hcount/vcount/bright.
module sprite_pixel_mux
    import sprite_pkg::*;
#(
    parameter int H_MIN    = VGA_H_MIN,
    parameter int H_MAX    = VGA_H_MAX,
    parameter int V_MAX    = VGA_V_MAX,
    parameter int HALF     = 5,
    parameter int FLOOR_Y  = 400,
    parameter int SAND_BOT = 475
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bright,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic [9:0]  xpos,
    input  logic [9:0]  ypos,
    input  logic [11:0] background,
    output logic [11:0] rgb
);

    localparam int SAND_LAST = (SAND_BOT < V_MAX) ? SAND_BOT : V_MAX;

    localparam logic signed [10:0] HALF_S   = 11'(HALF);
    localparam logic signed [10:0] SAND_X0  = 11'(H_MIN);
    localparam logic signed [10:0] SAND_X1  = 11'(H_MAX);
    localparam logic signed [10:0] SAND_Y0  = 11'(FLOOR_Y);
    localparam logic signed [10:0] SAND_Y1  = 11'(SAND_LAST);

    // 11-bit signed so that pos-HALF near the screen edge cannot wrap around
    logic signed [10:0] h, v, x, y;
    logic               in_sprite, in_sand;
    logic [11:0]        rgb_d;

    assign h = $signed({1'b0, hcount});
    assign v = $signed({1'b0, vcount});
    assign x = $signed({1'b0, xpos});
    assign y = $signed({1'b0, ypos});

    assign in_sprite = (h >= x - HALF_S) && (h <= x + HALF_S) &&
                       (v >= y - HALF_S) && (v <= y + HALF_S);
    assign in_sand   = (h >= SAND_X0) && (h <= SAND_X1) &&
                       (v >= SAND_Y0) && (v <= SAND_Y1);

    always_comb begin
        rgb_d = background;
        if (!bright)
            rgb_d = BLACK;
        else if (in_sprite)
            rgb_d = RED;
        else if (in_sand)
            rgb_d = SAND;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rgb <= BLACK;
        else
            rgb <= rgb_d;
    end

endmodule

// File: rtl/sprite_physics_controller.sv
// Single-sprite mover: horizontal walk with wrap or clamp, jump/fall with
// gravity onto a sand floor, background colour select and pixel painter.
//
//  state  | meaning
//  GROUND | resting on the sand, ypos pinned to the rest row
//  JUMP   | rising, vy negative, gravity slowing the climb
//  FALL   | descending, vy capped at VMAX, lands when it reaches rest
module sprite_physics_controller
    import sprite_pkg::*;
#(
    parameter int H_MIN    = VGA_H_MIN,
    parameter int H_MAX    = VGA_H_MAX,
    parameter int V_MIN    = VGA_V_MIN,
    parameter int V_MAX    = VGA_V_MAX,
    parameter int HALF     = 5,
    parameter int STEP     = 2,
    parameter int WRAP     = 1,
    parameter int FLOOR_Y  = 400,
    parameter int SAND_BOT = 475,
    parameter int JUMP_V0  = 8,
    parameter int GRAV     = 1,
    parameter int VMAX     = 8
) (
    input logic                         clk,
    input logic                         rst,
    sprite_physics_controller_if.slave  bus
);

    localparam logic [1:0] S_GROUND = GROUND;
    localparam logic [1:0] S_JUMP   = JUMP;
    localparam logic [1:0] S_FALL   = FALL;

    localparam logic signed [10:0] X_LO    = 11'(H_MIN + HALF);
    localparam logic signed [10:0] X_HI    = 11'(H_MAX - HALF);
    localparam logic signed [10:0] STEP_S  = 11'(STEP);
    localparam logic signed [10:0] Y_TOP   = 11'(V_MIN + HALF);
    localparam logic signed [10:0] Y_REST  = 11'(FLOOR_Y - 1 - HALF);
    localparam logic [9:0]         X_RESET = 10'((H_MIN + H_MAX + 1) / 2);
    localparam logic [9:0]         Y_RESET = 10'(FLOOR_Y - 1 - HALF);
    localparam logic signed [5:0]  VY_JUMP = 6'(-JUMP_V0);
    localparam logic signed [5:0]  VY_GRAV = 6'(GRAV);
    localparam logic signed [5:0]  VY_MAX  = 6'(VMAX);

    logic [1:0]         state, state_next;
    logic [9:0]         xpos, x_next;
    logic [9:0]         ypos, y_next;
    logic signed [5:0]  vy, vy_next, vy_inc;
    logic signed [10:0] x_sum, y_sum, vy_ext;
    logic [11:0]        background;

    always_comb begin
        x_sum = $signed({1'b0, xpos});
        if (bus.right)
            x_sum = x_sum + STEP_S;
        else if (bus.left)
            x_sum = x_sum - STEP_S;

        x_next = x_sum[9:0];
        if (x_sum > X_HI)
            x_next = (WRAP != 0) ? X_LO[9:0] : X_HI[9:0];
        else if (x_sum < X_LO)
            x_next = (WRAP != 0) ? X_HI[9:0] : X_LO[9:0];
    end

    assign vy_ext = {{5{vy[5]}}, vy};
    assign y_sum  = $signed({1'b0, ypos}) + vy_ext;
    assign vy_inc = vy + VY_GRAV;

    always_comb begin
        state_next = state;
        y_next     = ypos;
        vy_next    = vy;
        case (state)
            S_GROUND: begin
                y_next = Y_RESET;
                if (bus.up) begin
                    state_next = S_JUMP;
                    vy_next    = VY_JUMP;
                end
            end
            S_JUMP: begin
                if (y_sum <= Y_TOP) begin
                    y_next     = Y_TOP[9:0];
                    vy_next    = '0;
                    state_next = S_FALL;
                end else begin
                    y_next  = y_sum[9:0];
                    vy_next = vy_inc;
                    if (!vy_inc[5])
                        state_next = S_FALL;
                end
            end
            S_FALL: begin
                // snap onto the rest row instead of sinking into the sand
                if (y_sum >= Y_REST) begin
                    y_next     = Y_RESET;
                    vy_next    = '0;
                    state_next = S_GROUND;
                end else begin
                    y_next = y_sum[9:0];
                    if (bus.down || (vy_inc > VY_MAX))
                        vy_next = VY_MAX;
                    else
                        vy_next = vy_inc;
                end
            end
            default: begin
                state_next = S_GROUND;
                y_next     = Y_RESET;
                vy_next    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_GROUND;
            xpos       <= X_RESET;
            ypos       <= Y_RESET;
            vy         <= '0;
            background <= BG_DEFAULT;
        end else begin
            if (bus.move_tick) begin
                state <= state_next;
                xpos  <= x_next;
                ypos  <= y_next;
                vy    <= vy_next;
            end
            if (bus.right)
                background <= BG_R;
            else if (bus.left)
                background <= BG_L;
            else if (bus.down)
                background <= BG_D;
            else if (bus.up)
                background <= BG_U;
        end
    end

    assign bus.xpos       = xpos;
    assign bus.ypos       = ypos;
    assign bus.background = background;
    assign bus.airborne   = (state != S_GROUND);

    sprite_pixel_mux #(
        .H_MIN    (H_MIN),
        .H_MAX    (H_MAX),
        .V_MAX    (V_MAX),
        .HALF     (HALF),
        .FLOOR_Y  (FLOOR_Y),
        .SAND_BOT (SAND_BOT)
    ) u_pixel_mux (
        .clk        (clk),
        .rst        (rst),
        .bright     (bus.bright),
        .hcount     (bus.hCount),
        .vcount     (bus.vCount),
        .xpos       (xpos),
        .ypos       (ypos),
        .background (background),
        .rgb        (bus.rgb)
    );

endmodule
